// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI inter-cache coherence controller.
// Holds main-bus command codes, broadcast type codes, default widths,
// the buffered broadcast-request entry type and small decode helpers.
package mesi_isc_pkg;

    localparam int unsigned ISC_MBUS_CMD_WIDTH      = 3;
    localparam int unsigned ISC_ADDR_WIDTH          = 32;
    localparam int unsigned ISC_BROAD_TYPE_WIDTH    = 2;
    localparam int unsigned ISC_BROAD_ID_WIDTH      = 5;
    localparam int unsigned ISC_BREQ_FIFO_SIZE      = 2;
    localparam int unsigned ISC_BREQ_FIFO_SIZE_LOG2 = 1;
    localparam int unsigned ISC_CPU_COUNT           = 4;
    localparam int unsigned ISC_CPU_ID_WIDTH        = 2;

    // Main-bus command codes
    localparam logic [ISC_MBUS_CMD_WIDTH-1:0] MBUS_CMD_NOP      = 3'd0;
    localparam logic [ISC_MBUS_CMD_WIDTH-1:0] MBUS_CMD_WR       = 3'd1;
    localparam logic [ISC_MBUS_CMD_WIDTH-1:0] MBUS_CMD_RD       = 3'd2;
    localparam logic [ISC_MBUS_CMD_WIDTH-1:0] MBUS_CMD_WR_BROAD = 3'd3;
    localparam logic [ISC_MBUS_CMD_WIDTH-1:0] MBUS_CMD_RD_BROAD = 3'd4;

    // Broadcast request types
    localparam logic [ISC_BROAD_TYPE_WIDTH-1:0] BROAD_TYPE_WR = 2'd1;
    localparam logic [ISC_BROAD_TYPE_WIDTH-1:0] BROAD_TYPE_RD = 2'd2;

    // One buffered broadcast request
    typedef struct packed {
        logic [ISC_BROAD_TYPE_WIDTH-1:0] broad_type;
        logic [ISC_ADDR_WIDTH-1:0]       addr;
    } breq_entry_t;

    // True for the two command codes that this stage captures
    function automatic logic is_broad_cmd(input logic [ISC_MBUS_CMD_WIDTH-1:0] cmd);
        return (cmd == MBUS_CMD_WR_BROAD) || (cmd == MBUS_CMD_RD_BROAD);
    endfunction

    // Map a broadcast command code to its broadcast type
    function automatic logic [ISC_BROAD_TYPE_WIDTH-1:0] cmd_to_broad_type(
        input logic [ISC_MBUS_CMD_WIDTH-1:0] cmd
    );
        return (cmd == MBUS_CMD_RD_BROAD) ? BROAD_TYPE_RD : BROAD_TYPE_WR;
    endfunction

endpackage

// File: rtl/mesi_isc_breq_fifo.sv
// Single-clock request FIFO holding breq_entry_t items for one CPU.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   push        write wr_data (ignored when full)
//   wr_data     entry to store
//   pop         drop the head entry (ignored when empty)
//   rd_data_c   head entry, combinational from storage
//   full/empty  registered occupancy flags
// Flags reflect the count after the current edge, so a pop in one cycle
// only frees a slot for a push in the following cycle.
module mesi_isc_breq_fifo
    import mesi_isc_pkg::*;
#(
    parameter int unsigned DEPTH      = ISC_BREQ_FIFO_SIZE,
    parameter int unsigned DEPTH_LOG2 = ISC_BREQ_FIFO_SIZE_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  breq_entry_t wr_data,
    input  logic        pop,
    output breq_entry_t rd_data_c,
    output logic        full,
    output logic        empty
);

    localparam int unsigned CNT_WIDTH = DEPTH_LOG2 + 1;

    breq_entry_t           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_nxt_c;
    logic                  push_en_c;
    logic                  pop_en_c;

    // Pointer advance with wrap for non power-of-two depths
    function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
        return (p == DEPTH_LOG2'(DEPTH - 1)) ? '0 : p + DEPTH_LOG2'(1);
    endfunction

    assign push_en_c = push && !full;
    assign pop_en_c  = pop && !empty;

    // Occupancy after this edge
    always_comb begin
        count_nxt_c = count;
        if (push_en_c && !pop_en_c) begin
            count_nxt_c = count + CNT_WIDTH'(1);
        end else if (pop_en_c && !push_en_c) begin
            count_nxt_c = count - CNT_WIDTH'(1);
        end
    end

    // Pointers, count and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_en_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_en_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_WIDTH'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    // Storage needs no reset: validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_en_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast-request capture and arbitration stage of the MESI coherence
// controller. Captures WR_BROAD / RD_BROAD commands from four CPUs, acks
// each accepted command with a one-cycle pulse, buffers them per CPU and
// issues one request at a time round-robin as a tagged valid/ready request.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   mbus_cmd_array_i    per-CPU main-bus command, CPU n at [n*W +: W]
//   mbus_addr_array_i   per-CPU address, CPU n at [n*A +: A]
//   mbus_ack_o          one-cycle accept pulse per CPU
//   breq_valid_o        broadcast request valid
//   breq_ready_i        downstream accepts the request
//   breq_type_o         1 = write broadcast, 2 = read broadcast
//   breq_cpu_id_o       originating CPU
//   breq_id_o           transaction tag, wraps at 2^BROAD_ID_WIDTH
//   breq_addr_o         request address
module mesi_isc_breq_arb
    import mesi_isc_pkg::*;
#(
    parameter int unsigned MBUS_CMD_WIDTH      = ISC_MBUS_CMD_WIDTH,
    parameter int unsigned ADDR_WIDTH          = ISC_ADDR_WIDTH,
    parameter int unsigned BROAD_TYPE_WIDTH    = ISC_BROAD_TYPE_WIDTH,
    parameter int unsigned BROAD_ID_WIDTH      = ISC_BROAD_ID_WIDTH,
    parameter int unsigned BREQ_FIFO_SIZE      = ISC_BREQ_FIFO_SIZE,
    parameter int unsigned BREQ_FIFO_SIZE_LOG2 = ISC_BREQ_FIFO_SIZE_LOG2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ISC_CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
    input  logic [ISC_CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_array_i,
    output logic [ISC_CPU_COUNT-1:0]                mbus_ack_o,
    output logic                                   breq_valid_o,
    input  logic                                   breq_ready_i,
    output logic [BROAD_TYPE_WIDTH-1:0]            breq_type_o,
    output logic [ISC_CPU_ID_WIDTH-1:0]            breq_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]              breq_id_o,
    output logic [ADDR_WIDTH-1:0]                  breq_addr_o
);

    logic [ISC_CPU_COUNT-1:0]    accept_c;
    logic [ISC_CPU_COUNT-1:0]    fifo_full;
    logic [ISC_CPU_COUNT-1:0]    fifo_empty;
    logic [ISC_CPU_COUNT-1:0]    fifo_pop_c;
    breq_entry_t [ISC_CPU_COUNT-1:0] fifo_head_c;

    logic [ISC_CPU_ID_WIDTH-1:0] rr_q;
    logic [ISC_CPU_ID_WIDTH-1:0] scan_idx_c;
    logic [ISC_CPU_ID_WIDTH-1:0] win_id_c;
    logic                        win_valid_c;
    logic                        load_c;
    logic [BROAD_ID_WIDTH-1:0]   id_ctr_q;

    // Per-CPU accept slice and request FIFO
    for (genvar n = 0; n < ISC_CPU_COUNT; n++) begin : g_cpu
        logic [MBUS_CMD_WIDTH-1:0] cmd_c;
        breq_entry_t               entry_c;

        assign cmd_c = mbus_cmd_array_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];

        // The ack term blocks a second capture while the CPU is still
        // dropping the command it was just acked for.
        assign accept_c[n] = is_broad_cmd(cmd_c) && !fifo_full[n] && !mbus_ack_o[n];

        assign entry_c = '{
            broad_type: cmd_to_broad_type(cmd_c),
            addr:       ISC_ADDR_WIDTH'(mbus_addr_array_i[n*ADDR_WIDTH +: ADDR_WIDTH])
        };

        mesi_isc_breq_fifo #(
            .DEPTH      (BREQ_FIFO_SIZE),
            .DEPTH_LOG2 (BREQ_FIFO_SIZE_LOG2)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (accept_c[n]),
            .wr_data   (entry_c),
            .pop       (fifo_pop_c[n]),
            .rd_data_c (fifo_head_c[n]),
            .full      (fifo_full[n]),
            .empty     (fifo_empty[n])
        );
    end

    // Ack pulse follows the accept by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbus_ack_o <= '0;
        end else begin
            mbus_ack_o <= accept_c;
        end
    end

    // Round-robin winner: first non-empty FIFO from rr_q upward, mod 4
    always_comb begin
        win_valid_c = 1'b0;
        win_id_c    = rr_q;
        scan_idx_c  = rr_q;
        for (int unsigned k = 0; k < ISC_CPU_COUNT; k++) begin
            scan_idx_c = rr_q + ISC_CPU_ID_WIDTH'(k);
            if (!win_valid_c && !fifo_empty[scan_idx_c]) begin
                win_valid_c = 1'b1;
                win_id_c    = scan_idx_c;
            end
        end
    end

    // Output register may take a new request when empty or being drained
    assign load_c = !breq_valid_o || breq_ready_i;

    // Pop only the winning FIFO, and only at a load slot
    always_comb begin
        fifo_pop_c = '0;
        if (load_c && win_valid_c) begin
            fifo_pop_c[win_id_c] = 1'b1;
        end
    end

    // Output register, tag counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            breq_valid_o  <= 1'b0;
            breq_type_o   <= '0;
            breq_cpu_id_o <= '0;
            breq_id_o     <= '0;
            breq_addr_o   <= '0;
            id_ctr_q      <= '0;
            rr_q          <= '0;
        end else if (load_c) begin
            breq_valid_o <= win_valid_c;
            if (win_valid_c) begin
                breq_type_o   <= BROAD_TYPE_WIDTH'(fifo_head_c[win_id_c].broad_type);
                breq_addr_o   <= ADDR_WIDTH'(fifo_head_c[win_id_c].addr);
                breq_cpu_id_o <= win_id_c;
                breq_id_o     <= id_ctr_q;
                id_ctr_q      <= id_ctr_q + BROAD_ID_WIDTH'(1);
                rr_q          <= win_id_c + ISC_CPU_ID_WIDTH'(1);
            end
        end
    end

endmodule
